sync_fifo_p: RTL and testbench

Parametrised synchronous FIFO: the next generation of the team's 8x16 byte FIFO, generalised in data width and depth. It adds an occupancy count, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags, a synchronous flush, and defined simultaneous read/write behaviour, including at full and empty. It sits between a producer and a consumer in the same clock domain and is the standard buffering element for new datapaths.

---
 rtl/sync_fifo_p_pkg.sv | 20 ++
 rtl/sync_fifo_p_mem.sv | 33 +++
 rtl/sync_fifo_p.sv | 117 +++++++++++
 tb/tb_sync_fifo_p.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_p_pkg.sv
// Shared definitions for the parametrised synchronous FIFO: address sizing
// helper and the occupancy-update encoding used by the control path.
package sync_fifo_p_pkg;

  typedef enum logic [1:0] {
    CNT_HOLD = 2'd0,
    CNT_INC  = 2'd1,
    CNT_DEC  = 2'd2
  } cnt_op_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo_p_mem.sv
// DEPTH x WIDTH register array: one write port and one registered read port.
// The read register clears on reset and otherwise holds until the next read.
module sync_fifo_p_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             ck,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge ck) begin
    if (we) mem[waddr] <= wdata;
  end

  // Same-address read and write in one cycle returns the old entry.
  always_ff @(posedge ck) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/sync_fifo_p.sv
// Parametrised synchronous FIFO with occupancy count, programmable
// almost-full/almost-empty flags, sticky overflow/underflow and flush.
module sync_fifo_p
  import sync_fifo_p_pkg::*;
#(
  parameter int  WIDTH    = 8,
  parameter int  DEPTH    = 16,
  parameter int  AF_LEVEL = DEPTH - 2,
  parameter int  AE_LEVEL = 2,
  localparam int AW       = clog2(DEPTH)
) (
  input  logic             ck,
  input  logic             rst,
  input  logic             Clr,
  input  logic [WIDTH-1:0] Din,
  input  logic             Wen,
  input  logic             Ren,
  output logic [WIDTH-1:0] Dout,
  output logic             Dvalid,
  output logic             Fempty,
  output logic             Ffull,
  output logic             Falmost_empty,
  output logic             Falmost_full,
  output logic [AW:0]      Fcount,
  output logic             Ovf,
  output logic             Udf
);

  if (WIDTH < 1) begin : g_bad_width
    $error("sync_fifo_p: WIDTH must be at least 1");
  end
  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sync_fifo_p: DEPTH must be a power of two, at least 4");
  end
  if (!(AE_LEVEL >= 0 && AE_LEVEL < AF_LEVEL && AF_LEVEL <= DEPTH)) begin : g_bad_levels
    $error("sync_fifo_p: need 0 <= AE_LEVEL < AF_LEVEL <= DEPTH");
  end

  localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];
  localparam logic [AW:0] AF_C    = AF_LEVEL[AW:0];
  localparam logic [AW:0] AE_C    = AE_LEVEL[AW:0];

  logic          rd;
  logic          wr;
  logic          live;
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count_nxt;
  cnt_op_e       cnt_op;

  // Full/empty come from the registered flags, so a read at full frees the slot
  // for a same-cycle write, while a write into empty is never bypassed to a read.
  assign rd   = Ren && !Fempty;
  assign wr   = Wen && (!Ffull || rd);
  assign live = !rst && !Clr;

  always_comb begin
    cnt_op = CNT_HOLD;
    if (wr && !rd) begin
      cnt_op = CNT_INC;
    end else if (rd && !wr) begin
      cnt_op = CNT_DEC;
    end
  end

  always_comb begin
    count_nxt = Fcount;
    case (cnt_op)
      CNT_INC: count_nxt = Fcount + 1'b1;
      CNT_DEC: count_nxt = Fcount - 1'b1;
      default: count_nxt = Fcount;
    endcase
  end

  always_ff @(posedge ck) begin
    if (rst || Clr) begin
      wptr          <= '0;
      rptr          <= '0;
      Fcount        <= '0;
      Fempty        <= 1'b1;
      Ffull         <= 1'b0;
      Falmost_empty <= 1'b1;
      Falmost_full  <= 1'b0;
      Ovf           <= 1'b0;
      Udf           <= 1'b0;
      Dvalid        <= 1'b0;
    end else begin
      if (wr) wptr <= wptr + 1'b1;
      if (rd) rptr <= rptr + 1'b1;
      Fcount        <= count_nxt;
      Fempty        <= (count_nxt == '0);
      Ffull         <= (count_nxt == DEPTH_C);
      Falmost_empty <= (count_nxt <= AE_C);
      Falmost_full  <= (count_nxt >= AF_C);
      Ovf           <= Ovf | (Wen && !wr);
      Udf           <= Udf | (Ren && Fempty);
      Dvalid        <= rd;
    end
  end

  // A read or write coinciding with a flush is dropped; Dout holds across Clr.
  sync_fifo_p_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .ck    (ck),
    .rst   (rst),
    .we    (wr && live),
    .waddr (wptr),
    .wdata (Din),
    .re    (rd && live),
    .raddr (rptr),
    .rdata (Dout)
  );

endmodule

// File: tb/tb_sync_fifo_p.sv
// Bench for sync_fifo_p: two configurations share one stimulus stream; a
// queue-based model predicts status and read data, a monitor compares.
module tb_sync_fifo_p;

  localparam int AD = 16;
  localparam int BD = 4;

  logic        ck = 1'b0;
  logic        rst, clr, wen, ren;
  logic [31:0] din;

  logic [7:0]  a_dout;
  logic        a_dv, a_fe, a_ff, a_ae, a_af, a_ovf, a_udf;
  logic [4:0]  a_cnt;
  logic [31:0] b_dout;
  logic        b_dv, b_fe, b_ff, b_ae, b_af, b_ovf, b_udf;
  logic [2:0]  b_cnt;

  always #5 ck = ~ck;

  sync_fifo_p #(.WIDTH(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2)) dut_a (
    .ck(ck), .rst(rst), .Clr(clr), .Din(din[7:0]), .Wen(wen), .Ren(ren),
    .Dout(a_dout), .Dvalid(a_dv), .Fempty(a_fe), .Ffull(a_ff),
    .Falmost_empty(a_ae), .Falmost_full(a_af), .Fcount(a_cnt),
    .Ovf(a_ovf), .Udf(a_udf)
  );

  sync_fifo_p #(.WIDTH(32), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1)) dut_b (
    .ck(ck), .rst(rst), .Clr(clr), .Din(din), .Wen(wen), .Ren(ren),
    .Dout(b_dout), .Dvalid(b_dv), .Fempty(b_fe), .Ffull(b_ff),
    .Falmost_empty(b_ae), .Falmost_full(b_af), .Fcount(b_cnt),
    .Ovf(b_ovf), .Udf(b_udf)
  );

  typedef struct {
    int          cnt;
    logic        ovf;
    logic        udf;
    logic        dv;
    logic [31:0] dout;
  } st_t;

  logic [31:0] qa[$], qb[$];
  logic [31:0] da[$], db[$];
  st_t         sa[$], sb[$];
  logic        m_ovf [2];
  logic        m_udf [2];
  logic [31:0] m_dout [2];
  st_t         st;

  int checks;
  int errors;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: the FIFO as a bounded queue, stepped once per edge.
  task automatic model(input int i);
    int          depth;
    int          n;
    logic [31:0] mask;
    logic [31:0] v;
    bit          rd;
    bit          wr;
    st_t         s;
    depth = (i == 0) ? AD : BD;
    mask  = (i == 0) ? 32'h0000_00FF : 32'hFFFF_FFFF;
    n     = (i == 0) ? qa.size() : qb.size();
    s.dv  = 1'b0;
    if (rst || clr) begin
      if (i == 0) qa.delete(); else qb.delete();
      m_ovf[i] = 1'b0;
      m_udf[i] = 1'b0;
      if (rst) m_dout[i] = '0;
    end else begin
      rd = (ren === 1'b1) && (n > 0);
      wr = (wen === 1'b1) && ((n < depth) || rd);
      if (wen && !wr) m_ovf[i] = 1'b1;
      if (ren && n == 0) m_udf[i] = 1'b1;
      if (rd) begin
        if (i == 0) v = qa.pop_front(); else v = qb.pop_front();
        m_dout[i] = v;
        s.dv = 1'b1;
        if (i == 0) da.push_back(v); else db.push_back(v);
      end
      if (wr) begin
        if (i == 0) qa.push_back(din & mask); else qb.push_back(din & mask);
      end
    end
    s.cnt  = (i == 0) ? qa.size() : qb.size();
    s.ovf  = m_ovf[i];
    s.udf  = m_udf[i];
    s.dout = m_dout[i];
    if (i == 0) sa.push_back(s); else sb.push_back(s);
  endtask

  task automatic check_status(input int i, input st_t s, input logic [31:0] dout,
                              input logic dv, input logic fe, input logic ff,
                              input logic ae, input logic af, input logic [31:0] cnt,
                              input logic ovf, input logic udf);
    int    depth, ael, afl;
    string p;
    depth = (i == 0) ? AD : BD;
    ael   = (i == 0) ? 2 : 1;
    afl   = (i == 0) ? 14 : 3;
    p     = (i == 0) ? "a" : "b";
    chk({p, "_count"},  cnt,          32'(s.cnt));
    chk({p, "_empty"},  32'(fe),      32'(s.cnt == 0));
    chk({p, "_full"},   32'(ff),      32'(s.cnt == depth));
    chk({p, "_aempty"}, 32'(ae),      32'(s.cnt <= ael));
    chk({p, "_afull"},  32'(af),      32'(s.cnt >= afl));
    chk({p, "_ovf"},    32'(ovf),     32'(s.ovf));
    chk({p, "_udf"},    32'(udf),     32'(s.udf));
    chk({p, "_dvalid"}, 32'(dv),      32'(s.dv));
    chk({p, "_dout"},   dout,         s.dout);
  endtask

  // Monitor: status every modelled edge, read data whenever Dvalid is presented.
  always begin
    @(posedge ck);
    #1;
    if (sa.size() > 0) begin
      st = sa.pop_front();
      check_status(0, st, 32'(a_dout), a_dv, a_fe, a_ff, a_ae, a_af, 32'(a_cnt), a_ovf, a_udf);
    end
    if (sb.size() > 0) begin
      st = sb.pop_front();
      check_status(1, st, b_dout, b_dv, b_fe, b_ff, b_ae, b_af, 32'(b_cnt), b_ovf, b_udf);
    end
    if (a_dv === 1'b1) begin
      if (da.size() == 0) chk("a_data_unexpected", 32'(a_dout), 32'hDEAD_0000);
      else chk("a_data", 32'(a_dout), da.pop_front());
    end
    if (b_dv === 1'b1) begin
      if (db.size() == 0) chk("b_data_unexpected", b_dout, 32'hDEAD_0001);
      else chk("b_data", b_dout, db.pop_front());
    end
  end

  task automatic step(input logic r, input logic c, input logic w, input logic rd_i,
                      input logic [31:0] d);
    @(negedge ck);
    rst = r;
    clr = c;
    wen = w;
    ren = rd_i;
    din = d;
    model(0);
    model(1);
  endtask

  task automatic settle();
    @(posedge ck);
    #2;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: got running expected finished");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    int wp, rp;
    checks = 0;
    errors = 0;
    rst = 1'b1; clr = 1'b0; wen = 1'b0; ren = 1'b0; din = '0;
    m_ovf[0] = 1'b0; m_ovf[1] = 1'b0;
    m_udf[0] = 1'b0; m_udf[1] = 1'b0;
    m_dout[0] = '0;  m_dout[1] = '0;

    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    settle();
    chk("rst_a_count", 32'(a_cnt), 32'd0);
    chk("rst_a_empty", 32'(a_fe), 32'd1);
    chk("rst_a_dout", 32'(a_dout), 32'd0);
    chk("rst_b_dout", b_dout, 32'd0);

    for (int i = 0; i < AD; i++) begin
      step(0, 0, 1, 0, 32'(32'h11 + i));
      settle();
      chk("fill_a_afull_ramp", 32'(a_af), 32'(i + 1 >= 14));
    end
    chk("fill_a_full", 32'(a_ff), 32'd1);
    chk("fill_a_count", 32'(a_cnt), 32'd16);
    chk("fill_b_count", 32'(b_cnt), 32'd4);
    chk("fill_b_ovf", 32'(b_ovf), 32'd1);
    chk("fill_a_ovf", 32'(a_ovf), 32'd0);

    for (int i = 0; i < AD; i++) begin
      step(0, 0, 0, 1, 0);
      settle();
      chk("drain_a_seq", 32'(a_dout), 32'(32'h11 + i));
      chk("drain_a_dvalid", 32'(a_dv), 32'd1);
      chk("drain_a_aempty_ramp", 32'(a_ae), 32'(15 - i <= 2));
    end
    step(0, 0, 0, 0, 0);
    settle();
    chk("drain_a_dvalid_drop", 32'(a_dv), 32'd0);
    chk("drain_a_empty", 32'(a_fe), 32'd1);
    chk("drain_b_udf", 32'(b_udf), 32'd1);

    step(0, 1, 0, 1, 0);
    settle();
    chk("clr_a_dout_hold", 32'(a_dout), 32'h20);
    chk("clr_b_dout_hold", b_dout, 32'h14);
    chk("clr_b_ovf", 32'(b_ovf), 32'd0);
    chk("clr_b_udf", 32'(b_udf), 32'd0);

    for (int i = 0; i < AD; i++) step(0, 0, 1, 0, 32'(32'h30 + i));
    for (int i = 0; i < 40; i++) begin
      step(0, 0, 1, 1, 32'(32'h40 + i));
      settle();
      chk("full_rw_a_count", 32'(a_cnt), 32'd16);
      chk("full_rw_a_seq", 32'(a_dout), (i < 16) ? 32'(32'h30 + i) : 32'(32'h40 + i - 16));
    end
    chk("full_rw_a_ovf", 32'(a_ovf), 32'd0);

    for (int i = 0; i < AD; i++) step(0, 0, 0, 1, 0);
    step(0, 0, 1, 1, 32'hA5);
    settle();
    chk("empty_rw_a_count", 32'(a_cnt), 32'd1);
    chk("empty_rw_a_udf", 32'(a_udf), 32'd1);
    chk("empty_rw_a_dvalid", 32'(a_dv), 32'd0);
    chk("empty_rw_b_count", 32'(b_cnt), 32'd1);
    step(0, 0, 0, 1, 0);
    settle();
    chk("empty_rw_a_read", 32'(a_dout), 32'hA5);
    chk("empty_rw_b_read", b_dout, 32'hA5);

    for (int i = 0; i < AD; i++) step(0, 0, 1, 0, 32'(32'h60 + i));
    step(0, 0, 1, 0, 32'hEE);
    settle();
    chk("ovf_a_set", 32'(a_ovf), 32'd1);
    chk("ovf_a_count", 32'(a_cnt), 32'd16);
    step(0, 0, 0, 1, 0);
    settle();
    chk("ovf_a_head", 32'(a_dout), 32'h60);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
    settle();
    chk("ovf_a_sticky", 32'(a_ovf), 32'd1);
    step(0, 1, 0, 0, 0);
    settle();
    chk("clr2_a_count", 32'(a_cnt), 32'd0);
    chk("clr2_a_empty", 32'(a_fe), 32'd1);
    chk("clr2_a_ovf", 32'(a_ovf), 32'd0);
    chk("clr2_a_dout_hold", 32'(a_dout), 32'h60);

    wp = 50; rp = 50;
    for (int n = 0; n < 10000; n++) begin
      if (n % 400 == 0) begin
        wp = $urandom_range(15, 85);
        rp = $urandom_range(15, 85);
      end
      step(($urandom_range(0, 999) == 0), ($urandom_range(0, 249) == 0),
           ($urandom_range(0, 99) < wp), ($urandom_range(0, 99) < rp), $urandom);
    end

    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    settle();
    settle();
    chk("leftover_status", 32'(sa.size() + sb.size()), 32'd0);
    chk("leftover_data", 32'(da.size() + db.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
